// File: rtl/vex_uop_sequencer.sv
// Vector issue sequencer: splits one vector instruction into lane-wide micro-ops for vex.
// Optional VEX_SEQ_STATS_EN adds micro-op transfer and stall counters.
module vex_uop_sequencer #(
  parameter int VECTOR_REGISTERS = 32,
  parameter int VECTOR_LANES     = 8,
  parameter int VREG_ELEMS       = 8,
  localparam int RW    = $clog2(VECTOR_REGISTERS),
  localparam int MAXVL = 8 * VREG_ELEMS,
  localparam int VL_W  = $clog2(MAXVL) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid_i,
  output logic                    instr_ready_o,
  input  logic [VL_W-1:0]         vl_i,
  input  logic [RW-1:0]           dst_i,
  input  logic [RW-1:0]           src1_i,
  input  logic [RW-1:0]           src2_i,
  input  logic                    is_rdc_i,
  input  logic                    flush_i,
  input  logic                    vex_idle_i,
  output logic                    uop_valid_o,
  input  logic                    uop_ready_i,
  output logic [RW-1:0]           uop_dst_o,
  output logic [RW-1:0]           uop_src1_o,
  output logic [RW-1:0]           uop_src2_o,
  output logic [VECTOR_LANES-1:0] uop_lane_en_o,
  output logic                    uop_head_o,
  output logic                    uop_end_o,
  output logic                    uop_is_rdc_o,
  output logic                    busy_o,
  output logic [31:0]             stat_uops_o,
  output logic [31:0]             stat_stall_o
);

  localparam int EW = VL_W + 1;
  localparam int SW = VL_W + RW;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t          state;
  logic [VL_W-1:0] vl_q, elem_q;
  logic [RW-1:0]   dst_q, src1_q, src2_q;

  logic                    accept;
  logic [VL_W-1:0]         vl_clamp, sel_vl, sel_elem;
  logic [RW-1:0]           sel_dst, sel_src1, sel_src2;
  logic [RW-1:0]           n_dst, n_src1, n_src2;
  logic [VECTOR_LANES-1:0] n_lane;
  logic                    n_end;

  function automatic logic [RW-1:0] phys(input logic [RW-1:0] base, input logic [VL_W-1:0] elem);
    logic [SW-1:0] sum;
    sum = SW'(base) + SW'(elem / VL_W'(VREG_ELEMS));
    return RW'(sum % SW'(VECTOR_REGISTERS));
  endfunction

  assign accept   = (state == IDLE) && instr_ready_o && instr_valid_i;
  assign vl_clamp = (vl_i > VL_W'(MAXVL)) ? VL_W'(MAXVL) : vl_i;

  // Fields for the micro-op to be presented next: the first one of a new
  // instruction while idle, otherwise the one after the current micro-op.
  always_comb begin
    sel_vl   = vl_q;
    sel_dst  = dst_q;
    sel_src1 = src1_q;
    sel_src2 = src2_q;
    sel_elem = elem_q + VL_W'(VECTOR_LANES);
    if (state == IDLE) begin
      sel_vl   = vl_clamp;
      sel_dst  = dst_i;
      sel_src1 = src1_i;
      sel_src2 = src2_i;
      sel_elem = '0;
    end
    n_dst  = phys(sel_dst, sel_elem);
    n_src1 = phys(sel_src1, sel_elem);
    n_src2 = phys(sel_src2, sel_elem);
    n_lane = '0;
    for (int unsigned k = 0; k < VECTOR_LANES; k++)
      n_lane[k] = (EW'(sel_elem) + EW'(k)) < EW'(sel_vl);
    n_end = (EW'(sel_elem) + EW'(VECTOR_LANES)) >= EW'(sel_vl);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      vl_q          <= '0;
      elem_q        <= '0;
      dst_q         <= '0;
      src1_q        <= '0;
      src2_q        <= '0;
      instr_ready_o <= 1'b1;
      busy_o        <= 1'b0;
      uop_valid_o   <= 1'b0;
      uop_dst_o     <= '0;
      uop_src1_o    <= '0;
      uop_src2_o    <= '0;
      uop_lane_en_o <= '0;
      uop_head_o    <= 1'b0;
      uop_end_o     <= 1'b0;
      uop_is_rdc_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          instr_ready_o <= 1'b1;
          busy_o        <= 1'b0;
          if (accept) begin
            vl_q          <= vl_clamp;
            dst_q         <= dst_i;
            src1_q        <= src1_i;
            src2_q        <= src2_i;
            elem_q        <= '0;
            uop_is_rdc_o  <= is_rdc_i;
            instr_ready_o <= 1'b0;
            busy_o        <= 1'b1;
            // vl==0 stays idle but blocks acceptance for one cycle
            if (vl_clamp != '0) begin
              state         <= ISSUE;
              uop_valid_o   <= 1'b1;
              uop_dst_o     <= n_dst;
              uop_src1_o    <= n_src1;
              uop_src2_o    <= n_src2;
              uop_lane_en_o <= n_lane;
              uop_head_o    <= 1'b1;
              uop_end_o     <= n_end;
            end
          end
        end
        ISSUE: begin
          if (flush_i || (uop_ready_i && uop_end_o && !uop_is_rdc_o)) begin
            state         <= IDLE;
            uop_valid_o   <= 1'b0;
            instr_ready_o <= 1'b1;
            busy_o        <= 1'b0;
          end else if (uop_ready_i && uop_end_o) begin
            state       <= DRAIN;
            uop_valid_o <= 1'b0;
          end else if (uop_ready_i) begin
            elem_q        <= sel_elem;
            uop_dst_o     <= n_dst;
            uop_src1_o    <= n_src1;
            uop_src2_o    <= n_src2;
            uop_lane_en_o <= n_lane;
            uop_head_o    <= 1'b0;
            uop_end_o     <= n_end;
          end
        end
        DRAIN: begin
          if (flush_i || vex_idle_i) begin
            state         <= IDLE;
            instr_ready_o <= 1'b1;
            busy_o        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VEX_SEQ_STATS_EN
  logic [31:0] uops_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      uops_q  <= '0;
      stall_q <= '0;
    end else begin
      if (uop_valid_o && uop_ready_i)  uops_q  <= uops_q + 32'd1;
      if (uop_valid_o && !uop_ready_i) stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_uops_o  = uops_q;
  assign stat_stall_o = stall_q;
`else
  assign stat_uops_o  = '0;
  assign stat_stall_o = '0;
`endif

endmodule

// File: tb/tb_vex_uop_sequencer.sv
// Directed self-checking bench for vex_uop_sequencer at default parameters.
module tb_vex_uop_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic [6:0]  vl_i = '0;
  logic [4:0]  dst_i = '0, src1_i = '0, src2_i = '0;
  logic        is_rdc_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        vex_idle_i = 1'b1;
  logic        uop_valid_o;
  logic        uop_ready_i = 1'b1;
  logic [4:0]  uop_dst_o, uop_src1_o, uop_src2_o;
  logic [7:0]  uop_lane_en_o;
  logic        uop_head_o, uop_end_o, uop_is_rdc_o, busy_o;
  logic [31:0] stat_uops_o, stat_stall_o;

  int errors = 0;
  int checks = 0;

  vex_uop_sequencer #(.VECTOR_REGISTERS(32), .VECTOR_LANES(8), .VREG_ELEMS(8)) dut (
    .clk(clk), .rst(rst), .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .vl_i(vl_i), .dst_i(dst_i), .src1_i(src1_i), .src2_i(src2_i), .is_rdc_i(is_rdc_i),
    .flush_i(flush_i), .vex_idle_i(vex_idle_i), .uop_valid_o(uop_valid_o),
    .uop_ready_i(uop_ready_i), .uop_dst_o(uop_dst_o), .uop_src1_o(uop_src1_o),
    .uop_src2_o(uop_src2_o), .uop_lane_en_o(uop_lane_en_o), .uop_head_o(uop_head_o),
    .uop_end_o(uop_end_o), .uop_is_rdc_o(uop_is_rdc_o), .busy_o(busy_o),
    .stat_uops_o(stat_uops_o), .stat_stall_o(stat_stall_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers an instruction and returns after the accepting edge.
  task automatic issue(input logic [6:0] vl, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic rdc);
    int waited = 0;
    while (!instr_ready_o && waited < 20) begin
      step();
      waited++;
    end
    checks++;
    if (!instr_ready_o) begin
      errors++;
      $display("FAIL issue_wait: instr_ready_o got %0b exp 1 within 20 cycles", instr_ready_o);
    end
    instr_valid_i = 1'b1; vl_i = vl; dst_i = d; src1_i = s1; src2_i = s2; is_rdc_i = rdc;
    step();
    instr_valid_i = 1'b0; is_rdc_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({instr_ready_o, uop_valid_o, busy_o, uop_head_o, uop_end_o, uop_is_rdc_o} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags: got ready/valid/busy/head/end/rdc=%b exp 100000",
               {instr_ready_o, uop_valid_o, busy_o, uop_head_o, uop_end_o, uop_is_rdc_o});
    end
    checks++;
    if ({uop_dst_o, uop_src1_o, uop_src2_o, uop_lane_en_o} !== 23'd0 || stat_uops_o !== 0 || stat_stall_o !== 0) begin
      errors++;
      $display("FAIL reset_fields: got dst=%0d src1=%0d src2=%0d lane=%h uops=%0d stall=%0d exp all 0",
               uop_dst_o, uop_src1_o, uop_src2_o, uop_lane_en_o, stat_uops_o, stat_stall_o);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_lane;
    uop_ready_i = 1'b1;
    issue(7'd20, 5'd4, 5'd8, 5'd12, 1'b0);
    for (int k = 0; k < 3; k++) begin
      exp_lane = (k == 2) ? 8'h0F : 8'hFF;
      checks++;
      if (uop_valid_o !== 1'b1 || uop_dst_o !== 5'(4 + k) || uop_src1_o !== 5'(8 + k) || uop_src2_o !== 5'(12 + k)) begin
        errors++;
        $display("FAIL basic_regs k=%0d: got valid=%b dst=%0d src1=%0d src2=%0d exp 1 %0d %0d %0d",
                 k, uop_valid_o, uop_dst_o, uop_src1_o, uop_src2_o, 4 + k, 8 + k, 12 + k);
      end
      checks++;
      if (uop_lane_en_o !== exp_lane || uop_head_o !== (k == 0) || uop_end_o !== (k == 2) || instr_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL basic_ctrl k=%0d: got lane=%h head=%b end=%b ready=%b exp %h %b %b 0",
                 k, uop_lane_en_o, uop_head_o, uop_end_o, instr_ready_o, exp_lane, k == 0, k == 2);
      end
      step();
    end
    checks++;
    if (instr_ready_o !== 1'b1 || uop_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got ready=%b valid=%b busy=%b exp 1 0 0", instr_ready_o, uop_valid_o, busy_o);
    end
  endtask

  task automatic test_backpressure();
    rst = 1'b1; step(); rst = 1'b0;
    uop_ready_i = 1'b1;
    issue(7'd16, 5'd10, 5'd1, 5'd2, 1'b0);
    checks++;
    if (uop_dst_o !== 5'd10 || uop_end_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: got dst=%0d end=%b exp 10 0", uop_dst_o, uop_end_o);
    end
    step();
    uop_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) uop_ready_i = 1'b1;
      checks++;
      if (uop_valid_o !== 1'b1 || uop_dst_o !== 5'd11 || uop_lane_en_o !== 8'hFF || uop_end_o !== 1'b1 || uop_head_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold c=%0d: got valid=%b dst=%0d lane=%h end=%b head=%b exp 1 11 ff 1 0",
                 c, uop_valid_o, uop_dst_o, uop_lane_en_o, uop_end_o, uop_head_o);
      end
      step();
    end
`ifdef VEX_SEQ_STATS_EN
    checks++;
    if (stat_stall_o !== 32'd3 || stat_uops_o !== 32'd2) begin
      errors++;
      $display("FAIL bp_stats: got stall=%0d uops=%0d exp 3 2", stat_stall_o, stat_uops_o);
    end
`else
    checks++;
    if (stat_stall_o !== 32'd0 || stat_uops_o !== 32'd0) begin
      errors++;
      $display("FAIL bp_stats_off: got stall=%0d uops=%0d exp 0 0", stat_stall_o, stat_uops_o);
    end
`endif
    checks++;
    if (instr_ready_o !== 1'b1 || uop_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: got ready=%b valid=%b exp 1 0", instr_ready_o, uop_valid_o);
    end
  endtask

  task automatic test_wrap_clamp();
    logic [4:0] exp_d;
    uop_ready_i = 1'b1;
    issue(7'd24, 5'd30, 5'd31, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      exp_d = 5'(30 + k);
      checks++;
      if (uop_valid_o !== 1'b1 || uop_dst_o !== exp_d || uop_src1_o !== 5'(31 + k) || uop_lane_en_o !== 8'hFF) begin
        errors++;
        $display("FAIL wrap k=%0d: got valid=%b dst=%0d src1=%0d lane=%h exp 1 %0d %0d ff",
                 k, uop_valid_o, uop_dst_o, uop_src1_o, uop_lane_en_o, exp_d, 5'(31 + k));
      end
      step();
    end
    issue(7'd100, 5'd2, 5'd3, 5'd4, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (uop_valid_o !== 1'b1 || uop_dst_o !== 5'(2 + k) || uop_lane_en_o !== 8'hFF || uop_end_o !== (k == 7)) begin
        errors++;
        $display("FAIL clamp k=%0d: got valid=%b dst=%0d lane=%h end=%b exp 1 %0d ff %b",
                 k, uop_valid_o, uop_dst_o, uop_lane_en_o, uop_end_o, 2 + k, k == 7);
      end
      step();
    end
    checks++;
    if (uop_valid_o !== 1'b0 || instr_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL clamp_done: got valid=%b ready=%b exp 0 1", uop_valid_o, instr_ready_o);
    end
  endtask

  task automatic test_reduction();
    uop_ready_i = 1'b1;
    vex_idle_i = 1'b0;
    issue(7'd8, 5'd7, 5'd8, 5'd9, 1'b1);
    checks++;
    if (uop_valid_o !== 1'b1 || uop_head_o !== 1'b1 || uop_end_o !== 1'b1 || uop_is_rdc_o !== 1'b1 || uop_lane_en_o !== 8'hFF) begin
      errors++;
      $display("FAIL rdc_uop: got valid=%b head=%b end=%b rdc=%b lane=%h exp 1 1 1 1 ff",
               uop_valid_o, uop_head_o, uop_end_o, uop_is_rdc_o, uop_lane_en_o);
    end
    step();
    for (int c = 0; c < 5; c++) begin
      if (c == 4) vex_idle_i = 1'b1;
      checks++;
      if (instr_ready_o !== 1'b0 || uop_valid_o !== 1'b0 || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL rdc_drain c=%0d: got ready=%b valid=%b busy=%b exp 0 0 1", c, instr_ready_o, uop_valid_o, busy_o);
      end
      step();
    end
    checks++;
    if (instr_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rdc_done: got ready=%b busy=%b exp 1 0", instr_ready_o, busy_o);
    end
  endtask

  task automatic test_vl_zero();
    uop_ready_i = 1'b1;
    issue(7'd0, 5'd1, 5'd1, 5'd1, 1'b0);
    instr_valid_i = 1'b1; vl_i = 7'd8; dst_i = 5'd20; src1_i = 5'd21; src2_i = 5'd22;
    checks++;
    if (instr_ready_o !== 1'b0 || busy_o !== 1'b1 || uop_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL vl0_pulse: got ready=%b busy=%b valid=%b exp 0 1 0", instr_ready_o, busy_o, uop_valid_o);
    end
    step();
    checks++;
    if (instr_ready_o !== 1'b1 || busy_o !== 1'b0 || uop_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL vl0_after: got ready=%b busy=%b valid=%b exp 1 0 0", instr_ready_o, busy_o, uop_valid_o);
    end
    step();
    instr_valid_i = 1'b0;
    checks++;
    if (uop_valid_o !== 1'b1 || uop_dst_o !== 5'd20 || uop_end_o !== 1'b1) begin
      errors++;
      $display("FAIL vl0_next: got valid=%b dst=%0d end=%b exp 1 20 1", uop_valid_o, uop_dst_o, uop_end_o);
    end
    step();
  endtask

  task automatic test_flush_reset();
    uop_ready_i = 1'b1;
    issue(7'd32, 5'd12, 5'd13, 5'd14, 1'b0);
    step();
    flush_i = 1'b1;
    checks++;
    if (uop_dst_o !== 5'd13 || uop_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre: got dst=%0d valid=%b exp 13 1", uop_dst_o, uop_valid_o);
    end
    step();
    flush_i = 1'b0;
    checks++;
    if (uop_valid_o !== 1'b0 || instr_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_post: got valid=%b ready=%b busy=%b exp 0 1 0", uop_valid_o, instr_ready_o, busy_o);
    end
    issue(7'd32, 5'd5, 5'd6, 5'd7, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({instr_ready_o, uop_valid_o, busy_o, uop_head_o, uop_end_o, uop_is_rdc_o} !== 6'b100000 ||
        {uop_dst_o, uop_src1_o, uop_src2_o, uop_lane_en_o} !== 23'd0) begin
      errors++;
      $display("FAIL midreset: got flags=%b dst=%0d src1=%0d src2=%0d lane=%h exp 100000 0 0 0 00",
               {instr_ready_o, uop_valid_o, busy_o, uop_head_o, uop_end_o, uop_is_rdc_o},
               uop_dst_o, uop_src1_o, uop_src2_o, uop_lane_en_o);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap_clamp();
    test_reduction();
    test_vl_zero();
    test_flush_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
